// File: rtl/bist_pkg.sv
// Shared definitions for the logic-BIST sequencer.
//   state_t          : FSM state encoding (3-bit), also visible as bist_ctrl.state
//   DEF_PATTERNS/LAT : default pattern count and CUT response latency
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int DEF_PATTERNS = 1000;
  localparam int DEF_LAT      = 0;

endpackage

// File: rtl/bist_cycle_counter.sv
// Cycle counter used by the BIST sequencer to time the RUN phase.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (count -> 0)
//   clear        : synchronous clear to 0 (wins over enable)
//   enable       : increment by one this cycle
//   count        : current count value
//   at_term      : count equals the TERM parameter
module bist_cycle_counter #(
  parameter int CNT_W = 16,
  parameter int TERM  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_term = (count == TERM_C);

endmodule

// File: rtl/bist_ctrl.sv
// Logic-BIST sequencer: seeds the LFSR and MISR, steps PATTERNS patterns
// through the CUT, gates MISR compaction by the CUT latency LAT, then
// captures the signature and compares it with GOLDEN.
// Request/result semantics: start is a level sampled only in IDLE and DONE;
// done is a level that stays high (with pass/signature stable) until the
// next start or abort. abort wins over start in every state.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   start, abort             : run request / return to IDLE
//   misr_q [N:0]             : live MISR signature
//   lfsr_reset, lfsr_enable  : LFSR re-seed / advance
//   misr_reset, misr_enable  : MISR re-seed / compact
//   test_mode, busy, done    : status
//   pass, signature [N:0]    : registered result
// The FSM state is observable as the internal signal "state".
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int           N        = 120,
  parameter int           PATTERNS = DEF_PATTERNS,
  parameter int           LAT      = DEF_LAT,
  parameter logic [N:0]   GOLDEN   = '0,
  parameter int           CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [N:0] misr_q,
  output logic       lfsr_reset,
  output logic       lfsr_enable,
  output logic       misr_reset,
  output logic       misr_enable,
  output logic       test_mode,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [N:0] signature
);

  localparam logic [CNT_W-1:0] P_C   = CNT_W'(PATTERNS);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             at_term;
  logic             cnt_clear;
  logic             cnt_enable;

  bist_cycle_counter #(
    .CNT_W (CNT_W),
    .TERM  (PATTERNS + LAT - 1)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .count   (count),
    .at_term (at_term)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_INIT;
      ST_INIT:    state_next = ST_RUN;
      ST_RUN:     if (at_term) state_next = ST_COMPARE;
      ST_COMPARE: state_next = ST_DONE;
      ST_DONE:    if (start) state_next = ST_INIT;
      default:    state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
    end
  end

  // Outputs decode from the registered state only, so start/abort never
  // reach an output combinationally.
  always_comb begin
    lfsr_reset  = 1'b0;
    lfsr_enable = 1'b0;
    misr_reset  = 1'b0;
    misr_enable = 1'b0;
    test_mode   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;
    case (state)
      ST_INIT: begin
        lfsr_reset = 1'b1;
        misr_reset = 1'b1;
        test_mode  = 1'b1;
        busy       = 1'b1;
        cnt_clear  = 1'b1;
      end
      ST_RUN: begin
        test_mode   = 1'b1;
        busy        = 1'b1;
        cnt_enable  = 1'b1;
        lfsr_enable = (count < P_C);
        // count - LAT wraps to a value above PATTERNS while count < LAT,
        // so one unsigned compare covers LAT <= count < PATTERNS+LAT.
        misr_enable = ((count - LAT_C) < P_C);
      end
      ST_COMPARE: begin
        test_mode = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass      <= 1'b0;
      signature <= '0;
    end else if (abort) begin
      pass <= 1'b0;
    end else if (state_next == ST_INIT) begin
      pass      <= 1'b0;
      signature <= '0;
    end else if (state == ST_COMPARE) begin
      signature <= misr_q;
      pass      <= (misr_q == GOLDEN);
    end
  end

endmodule

// File: tb/tb_bist_ctrl.sv
// Bench for bist_ctrl: three instances (LAT=0 matching golden, LAT=3
// matching golden, LAT=0 golden off by bit 0) each wired to a small
// LFSR -> CUT (with LAT pipeline) -> MISR environment.
module tb_bist_ctrl;

  localparam int W = 32;
  localparam int P = 8;
  localparam logic [W-1:0] LSEED = 32'h0000_0001;
  localparam logic [W-1:0] MSEED = 32'hFFFF_0000;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] x);
    return {x[W-2:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  function automatic logic [W-1:0] cut_f(input logic [W-1:0] x);
    return x ^ (x >> 3) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [W-1:0] misr_step(input logic [W-1:0] m, input logic [W-1:0] d);
    return {m[W-2:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ d;
  endfunction

  function automatic logic [W-1:0] model_sig(input int n);
    logic [W-1:0] l;
    logic [W-1:0] m;
    l = LSEED;
    m = MSEED;
    for (int i = 0; i < n; i++) begin
      m = misr_step(m, cut_f(l));
      l = lfsr_step(l);
    end
    return m;
  endfunction

  localparam logic [W-1:0] MODEL = model_sig(P);

  function automatic int lat_of(input int g);
    return (g == 1) ? 3 : 0;
  endfunction

  function automatic logic [W-1:0] golden_of(input int g);
    return (g == 2) ? (MODEL ^ 32'h1) : MODEL;
  endfunction

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [2:0]   start, abort;
  logic [2:0]   lfsr_reset, lfsr_enable, misr_reset, misr_enable;
  logic [2:0]   test_mode, busy, done, pass;
  logic [W-1:0] misr_q [3];
  logic [W-1:0] signature [3];

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_pass_q[$];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int L  = lat_of(g);
    localparam int LI = (L == 0) ? 0 : L - 1;

    bist_ctrl #(
      .N        (W - 1),
      .PATTERNS (P),
      .LAT      (L),
      .GOLDEN   (golden_of(g)),
      .CNT_W    (16)
    ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start[g]),
      .abort       (abort[g]),
      .misr_q      (misr_q[g]),
      .lfsr_reset  (lfsr_reset[g]),
      .lfsr_enable (lfsr_enable[g]),
      .misr_reset  (misr_reset[g]),
      .misr_enable (misr_enable[g]),
      .test_mode   (test_mode[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .pass        (pass[g]),
      .signature   (signature[g])
    );

    logic [W-1:0] lfsr_r;
    logic [W-1:0] misr_r;
    logic [W-1:0] pipe [4];
    logic [W-1:0] resp;

    assign resp      = (L == 0) ? cut_f(lfsr_r) : pipe[LI];
    assign misr_q[g] = misr_r;

    always @(posedge clk) begin
      if (lfsr_reset[g]) lfsr_r <= LSEED;
      else if (lfsr_enable[g]) lfsr_r <= lfsr_step(lfsr_r);
      pipe[0] <= cut_f(lfsr_r);
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      if (misr_reset[g]) misr_r <= MSEED;
      else if (misr_enable[g]) misr_r <= misr_step(misr_r, resp);
    end
  end

  // Full run on instance g; caller sits on a falling edge. hold=1 keeps
  // start high through the INIT cycle.
  task automatic run_and_check(input int g, input int hold, input string name);
    int lat, nl, nm, nb, fl, fm, ll, lm, dj, diffs;
    logic [7:0]   got;
    logic [W-1:0] es;
    logic         ep;
    lat = lat_of(g);
    exp_q.push_back(MODEL);
    exp_pass_q.push_back(g != 2);
    start[g] = 1'b1;
    @(negedge clk);
    if (hold == 0) start[g] = 1'b0;
    got = {lfsr_reset[g], misr_reset[g], busy[g], test_mode[g],
           lfsr_enable[g], misr_enable[g], done[g], pass[g]};
    checks++;
    if (got !== 8'b1111_0000) begin
      errors++;
      $display("FAIL %s init_outputs got=%b exp=%b", name, got, 8'b1111_0000);
    end
    checks++;
    if (signature[g] !== '0) begin
      errors++;
      $display("FAIL %s init_signature got=%h exp=0", name, signature[g]);
    end
    nl = 0; nm = 0; nb = 0; fl = 0; fm = 0; ll = 0; lm = 0; dj = 0; diffs = 0;
    for (int j = 2; j <= 60 && dj == 0; j++) begin
      @(negedge clk);
      if (j == 2) begin
        start[g] = 1'b0;
        checks++;
        if ({lfsr_reset[g], misr_reset[g]} !== 2'b00) begin
          errors++;
          $display("FAIL %s reset_pulse_width got=%b exp=00", name, {lfsr_reset[g], misr_reset[g]});
        end
      end
      if (lfsr_enable[g]) begin nl++; if (fl == 0) fl = j; ll = j; end
      if (misr_enable[g]) begin nm++; if (fm == 0) fm = j; lm = j; end
      if (busy[g]) nb++;
      if (lfsr_enable[g] !== misr_enable[g]) diffs++;
      if (done[g]) dj = j;
    end
    checks++;
    if (dj != 11 + lat) begin
      errors++;
      $display("FAIL %s done_cycle got=%0d exp=%0d (0 = timeout)", name, dj, 11 + lat);
    end
    checks++;
    if (nl != P || nm != P) begin
      errors++;
      $display("FAIL %s enable_counts got=%0d/%0d exp=%0d/%0d", name, nl, nm, P, P);
    end
    checks++;
    if (fl != 2 || ll != P + 1) begin
      errors++;
      $display("FAIL %s lfsr_window got=%0d..%0d exp=%0d..%0d", name, fl, ll, 2, P + 1);
    end
    checks++;
    if (fm != 2 + lat || lm != P + 1 + lat) begin
      errors++;
      $display("FAIL %s misr_window got=%0d..%0d exp=%0d..%0d", name, fm, lm, 2 + lat, P + 1 + lat);
    end
    checks++;
    if (nb != P + lat + 1) begin
      errors++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", name, nb, P + lat + 1);
    end
    if (lat == 0) begin
      checks++;
      if (diffs != 0) begin
        errors++;
        $display("FAIL %s lat0_identical got=%0d differing cycles exp=0", name, diffs);
      end
    end
    checks++;
    if ({busy[g], test_mode[g]} !== 2'b00) begin
      errors++;
      $display("FAIL %s done_status got=%b exp=00", name, {busy[g], test_mode[g]});
    end
    es = exp_q.pop_front();
    ep = exp_pass_q.pop_front();
    checks++;
    if (signature[g] !== es) begin
      errors++;
      $display("FAIL %s signature got=%h exp=%h", name, signature[g], es);
    end
    checks++;
    if (pass[g] !== ep) begin
      errors++;
      $display("FAIL %s pass got=%b exp=%b", name, pass[g], ep);
    end
  endtask

  task automatic test_reset();
    start   = '0;
    abort   = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({lfsr_reset[g], lfsr_enable[g], misr_reset[g], misr_enable[g],
           test_mode[g], busy[g], done[g], pass[g]} !== 8'h00 || signature[g] !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got=%b sig=%h exp=0", g,
                 {lfsr_reset[g], lfsr_enable[g], misr_reset[g], misr_enable[g],
                  test_mode[g], busy[g], done[g], pass[g]}, signature[g]);
      end
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, lfsr_enable, misr_enable} !== 12'h000) begin
      errors++;
      $display("FAIL idle_after_reset got=%h exp=000", {busy, done, lfsr_enable, misr_enable});
    end
  endtask

  task automatic test_abort(input int at_count, input string name);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (1 + at_count) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_before_abort got=%b exp=1", name, busy[0]);
    end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({lfsr_reset[0], lfsr_enable[0], misr_reset[0], misr_enable[0],
           test_mode[0], busy[0], done[0], pass[0]} !== 8'h00) begin
        errors++;
        $display("FAIL %s idle_after_abort cycle%0d got=%b exp=00000000", name, j,
                 {lfsr_reset[0], lfsr_enable[0], misr_reset[0], misr_enable[0],
                  test_mode[0], busy[0], done[0], pass[0]});
      end
      @(negedge clk);
    end
    run_and_check(0, 0, {name, "_rerun"});
  endtask

  task automatic test_async_reset();
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({lfsr_reset[0], lfsr_enable[0], misr_reset[0], misr_enable[0],
         test_mode[0], busy[0], done[0], pass[0]} !== 8'h00 || signature[0] !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs got=%b sig=%h exp=0",
               {lfsr_reset[0], lfsr_enable[0], misr_reset[0], misr_enable[0],
                test_mode[0], busy[0], done[0], pass[0]}, signature[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({lfsr_reset[0], lfsr_enable[0], misr_reset[0], misr_enable[0], busy[0], done[0]} !== 6'h00) begin
        errors++;
        $display("FAIL idle_after_async_reset cycle%0d got=%b exp=000000", j,
                 {lfsr_reset[0], lfsr_enable[0], misr_reset[0], misr_enable[0], busy[0], done[0]});
      end
    end
    run_and_check(0, 0, "after_async_reset");
  endtask

  task automatic test_restart();
    run_and_check(0, 0, "restart_first");
    run_and_check(0, 1, "restart_second");
  endtask

  initial begin
    test_reset();
    run_and_check(0, 0, "nominal");
    run_and_check(1, 0, "latency");
    run_and_check(2, 0, "fail_detect");
    test_abort(4, "abort_mid_run");
    test_abort(P - 1, "abort_at_terminal");
    test_async_reset();
    test_restart();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

On-chip BIST sequencer for the logic-BIST path. It sits between the pattern-generating LFSR and the signature MISR, which is the downstream stage. It initialises both registers, runs a fixed number of test patterns through the circuit under test (CUT), and gates the MISR so that it compacts only valid CUT responses, accounting for CUT pipeline latency. At the end it compares the final signature against a golden value and reports pass/fail.

## Interface
- `N`, 120, MSB index of the MISR signature; the signature is N+1 bits, [N:0].
- `PATTERNS`, 1000, number of LFSR patterns applied per test; ≥ 1.
- `LAT`, 0, CUT response latency in cycles, from LFSR step to valid CUT output; 0 to 15.
- `GOLDEN`, 0, expected signature, N+1 bits.
- `CNT_W`, 16, width of the internal cycle counter; must satisfy 2^CNT_W > PATTERNS+LAT.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a test run; sampled in IDLE and DONE.
- `abort`  in  1  return to IDLE from any state; takes priority over `start`.
- `misr_q`  in  N+1  current MISR signature.
- `lfsr_reset`  out  1  active-high re-seed of the LFSR.
- `lfsr_enable`  out  1  advance the LFSR one pattern.
- `misr_reset`  out  1  active-high re-seed of the MISR.
- `misr_enable`  out  1  compact the CUT response this cycle.
- `test_mode`  out  1  selects LFSR patterns into the CUT inputs.
- `busy`  out  1  a test is in progress.
- `done`  out  1  result valid.
- `pass`  out  1  signature matched `GOLDEN`; meaningful only while `done`=1.
- `signature`  out  N+1  registered copy of `misr_q` captured in COMPARE.

## Operation
- FSM states: IDLE, INIT, RUN, COMPARE, DONE.
- **IDLE:** all strobes 0. When `start`=1, go to INIT.
- **INIT:** lasts one cycle.
  - `lfsr_reset`=1, `misr_reset`=1, `test_mode`=1, `busy`=1.
  - The counter is cleared to 0. Go to RUN.
- **RUN:** `test_mode`=1, `busy`=1. The counter increments every cycle.
  - `lfsr_enable`=1 while counter < PATTERNS.
  - `misr_enable`=1 while LAT ≤ counter < PATTERNS+LAT.
  - When counter = PATTERNS+LAT−1, go to COMPARE on the next edge.
  - Total RUN length is PATTERNS+LAT cycles. `misr_enable` is high for exactly PATTERNS cycles.
- **COMPARE:** lasts one cycle; `busy`=1, `test_mode`=1, strobes 0.
  - `signature` <= `misr_q`.
  - `pass` <= (`misr_q` == `GOLDEN`), full N+1-bit compare.
  - Go to DONE.
- **DONE:** `done`=1; `pass` and `signature` are held; `busy`=0, `test_mode`=0.
  - `start`=1 goes to INIT. This restarts the test and clears `done`, `pass`, and `signature` on entry to INIT.
- **abort** (any state): next state is IDLE; `done` and `pass` are cleared; `signature` is held.
- **start** held high through a run: ignored outside IDLE and DONE.

## Timing
- **Reset** (`reset_n`=0, asynchronous): state=IDLE, counter=0.
  - All outputs 0, including `signature` (all zeros), `pass`, and `done`.
  - Reset mid-run abandons the test immediately, with no further strobes.
- **Outputs:** every output is a registered or state-decoded signal with no combinational path from `start`/`abort` to outputs.
  - The only exception is `misr_q` → `signature`/`pass`, which is registered.
- **Start latency:** `start` sampled at edge k → INIT during cycle k+1 → first `lfsr_enable` in cycle k+2 → `done` asserted in cycle k+3+PATTERNS+LAT.
- **LAT=0:** `lfsr_enable` and `misr_enable` are identical waveforms.
- **Abort timing:** `abort` on the same edge as the counter reaching its terminal value still goes to IDLE; COMPARE is not entered.
- **Counter:** unsigned, CNT_W bits, never wraps within a legal configuration.
- **Illegal encoding:** an illegal state encoding recovers to IDLE.

## Structure
- Shared package `bist_pkg`:
  - state encoding constants `ST_IDLE`, `ST_INIT`, `ST_RUN`, `ST_COMPARE`, `ST_DONE` (3-bit);
  - the default `PATTERNS`/`LAT` constants.
- Sub-module `bist_cycle_counter`: CNT_W-bit counter with synchronous clear, enable, and a terminal-match output. It is instantiated once.
- The FSM and output decode live in `bist_ctrl`.

## Test plan
- **Nominal pass:** PATTERNS=8, LAT=0, `GOLDEN` = model signature; pulse `start`.
  - `lfsr_enable` and `misr_enable` each high for 8 cycles.
  - `done`=1 at cycle start+11; `pass`=1; `signature`=`GOLDEN`.
- **Latency skew:** PATTERNS=8, LAT=3.
  - `misr_enable` rises 3 cycles after `lfsr_enable` and falls 3 cycles after it.
  - 8 high cycles each; `done` at start+14.
- **Fail detect:** `GOLDEN` differs from the model in bit 0 only.
  - `pass`=0, `done`=1, `signature` equals the model value.
- **Abort mid-RUN:** assert `abort` at counter=4.
  - Next cycle: IDLE, all strobes 0, `done`=0, `busy`=0.
  - A subsequent `start` gives a full correct run.
- **Async reset mid-run:** drop `reset_n` between edges during RUN.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, IDLE; no strobes until `start`.
- **Restart from DONE:** after a pass, hold `start`=1 in DONE.
  - INIT asserts `lfsr_reset`/`misr_reset` for exactly 1 cycle.
  - `done` and `pass` clear; the second run reproduces the identical signature.
